fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction fetch stage for the 16-bit processor. It owns the program counter, issues in-order word reads to instruction memory, buffers returned words in a small prefetch FIFO and hands them to the decode stage through a valid/ready handshake. It also handles redirects from execute (branch/jump), discarding stale in-flight fetches.

## Interface

Parameters:
- `ADDR_W`, 16, instruction address width, word-addressed
- `DEPTH`, 4, prefetch FIFO entries and maximum outstanding memory reads; power of two, ≥2
- `RESET_PC`, 0, PC value after reset

Ports:
- `clk`  input  1  clock; all state updates on rising edge
- `reset`  input  1  asynchronous, active-low reset
- `mem_req`  output  1  read request to instruction memory
- `mem_addr`  output  ADDR_W  word address of request
- `mem_gnt`  input  1  memory accepts request when `mem_req && mem_gnt`
- `mem_rvalid`  input  1  read data valid; responses return in request order, latency ≥1 cycle
- `mem_rdata`  input  16  instruction word
- `instr_valid`  output  1  FIFO head valid
- `instr`  output  16  FIFO head instruction
- `instr_pc`  output  ADDR_W  address of `instr`
- `instr_ready`  input  1  decode consumes head when `instr_valid && instr_ready`
- `redirect_valid`  input  1  branch/jump taken
- `redirect_pc`  input  ADDR_W  new fetch address
- `halted`  output  1  fetch stopped on HALT (0 when `FETCH_HALT_EN` undefined)

## Operation

- Registers: `fetch_pc`, FIFO (data + pc per entry, rd/wr pointers, count), `outstanding` (granted, not yet returned), `drop_cnt` (responses to discard), state.
- Credit rule: `mem_req = (state==RUN) && !redirect_valid && (count + outstanding < DEPTH)`. Guarantees every response has a FIFO slot; no response is ever lost or stalled.
- `mem_addr = fetch_pc`. On grant, `fetch_pc` increments by 1, wrapping at 2^ADDR_W to 0.
- Each response: if `drop_cnt > 0`, discard and decrement; else enqueue `{mem_rdata, pc}`, pc taken from a parallel in-flight address record (or `head_pc + count` bookkeeping).
- Redirect: FIFO flushed (count 0), `fetch_pc <= redirect_pc`, `drop_cnt <= outstanding` counted after this cycle's grant/response (grant that cycle impossible; a response that cycle is dropped). State returns to RUN. Redirect has priority over enqueue, dequeue, and HALT detection in the same cycle.
- Dequeue in same cycle as enqueue: count unchanged, both occur.
- States: RUN (issuing), HALT (no issuing; only with `FETCH_HALT_EN`). RUN→HALT on enqueue of HALT word; HALT→RUN only on redirect or reset.

## Timing

- Reset values: `mem_req` 0 during reset, `mem_addr`=RESET_PC, `instr_valid` 0, `instr` 0, `instr_pc` 0, `halted` 0; counters/pointers 0, state RUN.
- First `mem_req` asserted in first cycle after reset deasserts.
- Response enqueued at edge where `mem_rvalid`=1; `instr_valid` visible next cycle (no bypass). Min fetch-to-decode latency: grant cycle + memory latency + 1.
- With 1-cycle memory and `instr_ready` held high: one instruction per cycle sustained.
- Redirect at edge N: `instr_valid`=0 at N+1; `mem_req` for `redirect_pc` at N+1.
- Reset asserted mid-operation clears all state immediately; responses arriving after reset release are not expected (memory reset together).

## Configuration

- `FETCH_HALT_EN` defined: enqueued word with `instr[15:12]==4'hF` is the last enqueued; state→HALT, `halted`=1 next cycle, `drop_cnt <= outstanding` so later responses are discarded; HALT word still delivered to decode.
- Undefined: no opcode inspection, HALT state absent, `halted` tied 0, 4'hF words fetched like any other.

## Test plan

- Sequential fetch, 1-cycle memory, mem[i]=0x1000+i, ready=1 -> instr 0x1000..0x1009 on consecutive cycles, `instr_pc` 0..9.
- `instr_ready`=0 for 10 cycles, DEPTH=4 -> exactly 4 grants, `mem_req` low, FIFO full; release -> words in order, none lost.
- 3-cycle memory, redirect to 0x0040 with 3 outstanding -> 3 responses dropped, next `instr`=mem[0x40], `instr_pc`=0x40.
- Redirect coincident with `mem_rvalid` and `instr_ready` -> that response dropped, no dequeue counted, FIFO empty next cycle.
- `FETCH_HALT_EN`, mem[5]=0xF000 -> `instr_pc` 5 delivered, `halted`=1, no further `mem_req`; redirect to 0 -> `halted`=0, fetch resumes at 0.
- Reset low while FIFO holds 3 entries -> `instr_valid`=0 immediately; after release fetch restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : fetch_unit
// Brief    : Instruction fetch stage. Owns the program counter, issues
//            credit-limited in-order word reads, buffers returned words in a
//            prefetch FIFO for decode and flushes on execute redirects,
//            discarding responses of fetches that were in flight.
// Options  : FETCH_HALT_EN - when defined, a delivered word with opcode 4'hF
//            stops fetching until the next redirect.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_unit #(
  parameter int                ADDR_W   = 16,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [15:0]       mem_rdata,
  output logic              instr_valid,
  output logic [15:0]       instr,
  output logic [ADDR_W-1:0] instr_pc,
  input  logic              instr_ready,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              halted
);

  localparam int                 c_PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int                 c_CNT_W = c_PTR_W + 1;
  localparam logic [c_CNT_W:0]   c_DEPTH = (c_CNT_W + 1)'(DEPTH);

  // Architectural state
  logic [ADDR_W-1:0]  r_fetch_pc;
  logic [ADDR_W-1:0]  r_enq_pc;      // address of the next word to be enqueued
  logic [15:0]        r_data [DEPTH];
  logic [ADDR_W-1:0]  r_pc   [DEPTH];
  logic [c_PTR_W-1:0] r_rd_ptr;
  logic [c_PTR_W-1:0] r_wr_ptr;
  logic [c_CNT_W-1:0] r_count;
  logic [c_CNT_W-1:0] r_outstanding;
  logic [c_CNT_W-1:0] r_drop_cnt;

  // Per-cycle decisions
  logic               w_run;
  logic [c_CNT_W:0]   w_credit_sum;
  logic               w_grant;
  logic               w_enq;
  logic               w_deq;
  logic               w_drop_dec;
  logic               w_halt_hit;
  logic [c_CNT_W-1:0] w_out_next;

  // Outstanding reads are counted against FIFO space so every response lands.
  assign w_credit_sum = {1'b0, r_count} + {1'b0, r_outstanding};
  assign mem_req      = reset && w_run && !redirect_valid && (w_credit_sum < c_DEPTH);
  assign mem_addr     = r_fetch_pc;
  assign w_grant      = mem_req && mem_gnt;

  // Responses are discarded while a drop debt remains or when a redirect flushes.
  assign w_drop_dec   = mem_rvalid && (r_drop_cnt != '0);
  assign w_enq        = mem_rvalid && (r_drop_cnt == '0) && !redirect_valid;
  assign w_deq        = instr_valid && instr_ready && !redirect_valid;
  assign w_out_next   = r_outstanding + c_CNT_W'(w_grant) - c_CNT_W'(mem_rvalid);

  assign instr_valid  = (r_count != '0);
  assign instr        = r_data[r_rd_ptr];
  assign instr_pc     = r_pc[r_rd_ptr];

`ifdef FETCH_HALT_EN
  typedef enum logic [0:0] {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } state_t;

  state_t r_state;
  logic   r_halted;

  assign w_run      = (r_state == ST_RUN);
  assign w_halt_hit = w_enq && (mem_rdata[15:12] == 4'hF);
  assign halted     = r_halted;

  // Run/halt sequencing; redirect always wins and resumes fetching.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= ST_RUN;
      r_halted <= 1'b0;
    end else if (redirect_valid) begin
      r_state  <= ST_RUN;
      r_halted <= 1'b0;
    end else if (w_halt_hit) begin
      r_state  <= ST_HALT;
      r_halted <= 1'b1;
    end
  end
`else
  assign w_run      = 1'b1;
  assign w_halt_hit = 1'b0;
  assign halted     = 1'b0;
`endif

  // Program counter: reload on redirect, advance on each accepted request.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_fetch_pc <= RESET_PC;
    end else if (redirect_valid) begin
      r_fetch_pc <= redirect_pc;
    end else if (w_grant) begin
      r_fetch_pc <= r_fetch_pc + ADDR_W'(1);
    end
  end

  // In-flight tracking and drop debt: on flush or halt every read still in
  // flight after this cycle must be thrown away when it returns.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_outstanding <= '0;
      r_drop_cnt    <= '0;
    end else begin
      r_outstanding <= w_out_next;
      if (redirect_valid || w_halt_hit) begin
        r_drop_cnt <= w_out_next;
      end else if (w_drop_dec) begin
        r_drop_cnt <= r_drop_cnt - c_CNT_W'(1);
      end
    end
  end

  // FIFO bookkeeping: pointers, occupancy and the pc of the next enqueued word.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
      r_enq_pc <= RESET_PC;
    end else if (redirect_valid) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
      r_enq_pc <= redirect_pc;
    end else begin
      if (w_enq) begin
        r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
        r_enq_pc <= r_enq_pc + ADDR_W'(1);
      end
      if (w_deq) begin
        r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
      end
      r_count <= r_count + c_CNT_W'(w_enq) - c_CNT_W'(w_deq);
    end
  end

  // FIFO storage: instruction word plus its fetch address.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_data[i] <= '0;
        r_pc[i]   <= '0;
      end
    end else if (w_enq) begin
      r_data[r_wr_ptr] <= mem_rdata;
      r_pc[r_wr_ptr]   <= r_enq_pc;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_unit
// Brief    : Self-checking bench for fetch_unit: in-order memory model with
//            configurable latency, queue-based fetch model compared every
//            cycle, plus hand-computed checks for each directed scenario.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

  localparam int          ADDR_W   = 16;
  localparam int          DEPTH    = 4;
  localparam logic [15:0] RESET_PC = 16'h0000;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_gnt = 1'b1;
  logic        mem_rvalid = 1'b0;
  logic [15:0] mem_rdata = 16'h0000;
  logic        instr_valid;
  logic [15:0] instr;
  logic [15:0] instr_pc;
  logic        instr_ready = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [15:0] redirect_pc = 16'h0000;
  logic        halted;

  always #5 clk = ~clk;

  fetch_unit #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .reset(reset),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc),
    .instr_ready(instr_ready),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .halted(halted)
  );

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  // Memory model: in-order responses after a fixed latency
  int          lat = 1;
  bit          halt_word_on = 1'b0;
  logic [15:0] mq_addr[$];
  int          mq_due[$];
  int          dut_grants = 0;

  // Fetch model: words waiting for decode and reads in flight
  typedef struct packed {
    logic [15:0] data;
    logic [15:0] pc;
  } ent_t;
  ent_t        m_fifo[$];
  logic [15:0] m_inf_addr[$];
  bit          m_inf_drop[$];
  logic [15:0] m_pc = RESET_PC;
  bit          m_halted = 1'b0;

  // Words handed to decode
  logic [15:0] d_data[$];
  logic [15:0] d_pc[$];
  int          d_cyc[$];

  function automatic logic [15:0] mem_word(logic [15:0] a);
    if (halt_word_on && a == 16'h0005) return 16'hF000;
    return 16'h1000 + a;
  endfunction

  function automatic bit exp_req();
    return !m_halted && !redirect_valid && ((m_fifo.size() + m_inf_addr.size()) < DEPTH);
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic clear_logs();
    d_data.delete();
    d_pc.delete();
    d_cyc.delete();
  endtask

  task automatic compare_outputs();
    chk("mem_req", mem_req, exp_req());
    chk("mem_addr", mem_addr, m_pc);
    chk("instr_valid", instr_valid, m_fifo.size() != 0);
    if (m_fifo.size() != 0) begin
      chk("instr", instr, m_fifo[0].data);
      chk("instr_pc", instr_pc, m_fifo[0].pc);
    end
    chk("halted", halted, m_halted);
  endtask

  task automatic model_update();
    bit          mg;
    bit          drop;
    logic [15:0] a;
    ent_t        e;
    mg = exp_req() && mem_gnt;
    if (!redirect_valid && m_fifo.size() != 0 && instr_ready) begin
      e = m_fifo.pop_front();
      d_data.push_back(e.data);
      d_pc.push_back(e.pc);
      d_cyc.push_back(cyc);
    end
    if (mem_rvalid) begin
      if (m_inf_addr.size() == 0) begin
        chk("inflight_reads", m_inf_addr.size(), 1);
      end else begin
        a    = m_inf_addr.pop_front();
        drop = m_inf_drop.pop_front();
        if (!drop && !redirect_valid) begin
          e.data = mem_rdata;
          e.pc   = a;
          m_fifo.push_back(e);
`ifdef FETCH_HALT_EN
          if (mem_rdata[15:12] == 4'hF) m_halted = 1'b1;
`endif
        end
      end
    end
    if (mg) begin
      m_inf_addr.push_back(m_pc);
      m_inf_drop.push_back(1'b0);
      m_pc = m_pc + 16'd1;
    end
    if (m_halted || redirect_valid) begin
      foreach (m_inf_drop[i]) m_inf_drop[i] = 1'b1;
    end
    if (redirect_valid) begin
      m_fifo.delete();
      m_pc     = redirect_pc;
      m_halted = 1'b0;
    end
  endtask

  // One clock cycle; entered and left just after a falling edge.
  task automatic step();
    bit          g;
    logic [15:0] ga;
    if (mq_due.size() > 0 && mq_due[0] <= cyc) begin
      mem_rvalid = 1'b1;
      mem_rdata  = mem_word(mq_addr[0]);
      void'(mq_addr.pop_front());
      void'(mq_due.pop_front());
    end else begin
      mem_rvalid = 1'b0;
      mem_rdata  = 16'h0000;
    end
    #1;
    compare_outputs();
    g  = mem_req && mem_gnt;
    ga = mem_addr;
    @(posedge clk);
    model_update();
    if (g) begin
      dut_grants++;
      mq_addr.push_back(ga);
      mq_due.push_back(cyc + lat);
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic do_reset(int cycles);
    reset          = 1'b0;
    redirect_valid = 1'b0;
    mem_rvalid     = 1'b0;
    instr_ready    = 1'b0;
    mem_gnt        = 1'b1;
    #1;
    chk("rst_instr_valid", instr_valid, 0);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_addr", mem_addr, RESET_PC);
    chk("rst_instr", instr, 0);
    chk("rst_instr_pc", instr_pc, 0);
    chk("rst_halted", halted, 0);
    repeat (cycles) @(posedge clk);
    m_fifo.delete();
    m_inf_addr.delete();
    m_inf_drop.delete();
    m_pc     = RESET_PC;
    m_halted = 1'b0;
    mq_addr.delete();
    mq_due.delete();
    clear_logs();
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    int n0;
    @(negedge clk);

    // Sequential fetch with 1-cycle memory and decode always ready
    do_reset(2);
    lat = 1; instr_ready = 1'b1;
    t0 = cyc;
    repeat (14) step();
    chk("t1_ndeliv", d_data.size(), 12);
    if (d_cyc.size() > 0) chk("t1_first_latency", d_cyc[0] - t0, 2);
    for (int i = 0; i < 10 && i < d_data.size(); i++) begin
      chk("t1_data", d_data[i], 16'h1000 + 16'(i));
      chk("t1_pc", d_pc[i], i);
      if (i > 0) chk("t1_back_to_back", d_cyc[i] - d_cyc[i-1], 1);
    end

    // Decode stalled: credit limit stops requests at DEPTH
    do_reset(2);
    lat = 1; instr_ready = 1'b0; dut_grants = 0;
    repeat (10) step();
    chk("t2_grants", dut_grants, 4);
    #1;
    chk("t2_full_valid", instr_valid, 1);
    chk("t2_req_low", mem_req, 0);
    instr_ready = 1'b1;
    for (int k = 0; k < 16; k++) begin
      mem_gnt = ($urandom_range(0, 3) != 0);
      step();
    end
    mem_gnt = 1'b1;
    chk("t2_drained_ge4", d_data.size() >= 4, 1);
    for (int i = 0; i < d_data.size(); i++) begin
      chk("t2_order_pc", d_pc[i], i);
      chk("t2_order_data", d_data[i], 16'h1000 + 16'(i));
    end

    // 3-cycle memory, redirect with three reads in flight
    do_reset(2);
    lat = 3; instr_ready = 1'b1;
    repeat (3) step();
    redirect_valid = 1'b1; redirect_pc = 16'h0040;
    step();
    redirect_valid = 1'b0;
    repeat (10) step();
    chk("t3_deliv_nonzero", d_data.size() > 0, 1);
    if (d_data.size() > 0) begin
      chk("t3_first_pc", d_pc[0], 16'h0040);
      chk("t3_first_data", d_data[0], 16'h1040);
    end

    // Redirect together with a response and a consuming decode
    do_reset(2);
    lat = 1; instr_ready = 1'b1;
    repeat (4) step();
    #1;
    chk("t4_pre_valid", instr_valid, 1);
    redirect_valid = 1'b1; redirect_pc = 16'h0020;
    step();
    redirect_valid = 1'b0;
    n0 = d_pc.size();
    #1;
    chk("t4_flushed", instr_valid, 0);
    chk("t4_req_new_pc", mem_addr, 16'h0020);
    repeat (6) step();
    if (d_pc.size() > n0) begin
      chk("t4_first_pc", d_pc[n0], 16'h0020);
      chk("t4_first_data", d_data[n0], 16'h1020);
    end else begin
      chk("t4_deliv_after_redirect", d_pc.size() - n0, 1);
    end

    // Opcode 4'hF word at address 5
    do_reset(2);
    halt_word_on = 1'b1; lat = 2; instr_ready = 1'b1;
    repeat (20) step();
`ifdef FETCH_HALT_EN
    #1;
    chk("t5_halted", halted, 1);
    chk("t5_req_off", mem_req, 0);
    chk("t5_ndeliv", d_pc.size(), 6);
    if (d_pc.size() > 0) chk("t5_last_pc", d_pc[d_pc.size()-1], 16'h0005);
    redirect_valid = 1'b1; redirect_pc = 16'h0000;
    step();
    redirect_valid = 1'b0;
    #1;
    chk("t5_resume_halted", halted, 0);
    chk("t5_resume_req", mem_req, 1);
    chk("t5_resume_addr", mem_addr, 16'h0000);
    repeat (3) step();
`else
    #1;
    chk("t5_not_halted", halted, 0);
    chk("t5_ndeliv", d_pc.size(), 17);
    if (d_data.size() > 6) begin
      chk("t5_f_word", d_data[5], 16'hF000);
      chk("t5_after_f", d_pc[6], 16'h0006);
    end
`endif
    halt_word_on = 1'b0;

    // Reset while the FIFO holds three words
    do_reset(2);
    lat = 1; instr_ready = 1'b0;
    repeat (4) step();
    chk("t6_model_entries", m_fifo.size(), 3);
    #1;
    chk("t6_pre_valid", instr_valid, 1);
    do_reset(2);
    #1;
    chk("t6_restart_req", mem_req, 1);
    chk("t6_restart_addr", mem_addr, RESET_PC);
    repeat (4) step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
